lcd_tft_timing: RTL
===================

Name: lcd_tft_timing

Overview:
- Output stage directly downstream of the palette serializer in the LCD pipeline.
- Generates TFT raster timing (HSYNC, VSYNC, DE) from frame-geometry inputs.
- Consumes one pixel per cycle from the serializer during the active window and drives the serializer's stall and startpipe inputs.
- Registers the pixel onto the panel data bus and flags underflow when no valid pixel is ready.

Parameters:
- H_W, 11, width of horizontal config fields and counter
- V_W, 11, width of vertical config fields and counter
- PIX_W, 24, pixel and panel data width

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-low reset
- enable  in  1  LcdEn; 1 = run timing, 0 = idle
- ppl  in  H_W  active pixels per line minus 1
- hsw  in  H_W  hsync width minus 1
- hbp  in  H_W  horizontal back porch minus 1
- hfp  in  H_W  horizontal front porch minus 1
- lpp  in  V_W  active lines per frame minus 1
- vsw  in  V_W  vsync width, in lines, minus 1
- vbp  in  V_W  vertical back porch minus 1
- vfp  in  V_W  vertical front porch minus 1
- ihs  in  1  invert hsync (1 = active-low)
- ivs  in  1  invert vsync (1 = active-low)
- pixel  in  PIX_W  pixel from serializer
- pixel_valid  in  1  pixel is valid
- stall  out  1  hold the serializer pipeline
- startpipe  out  1  serializer run enable
- lcd_hsync  out  1  horizontal sync
- lcd_vsync  out  1  vertical sync
- lcd_de  out  1  data enable
- lcd_data  out  PIX_W  panel data
- underflow  out  1  sticky; active pixel slot had no valid pixel

Behaviour:
- Reset (reset=0 sampled at an edge):
  - state IDLE, all counters 0, underflow 0, lcd_data 0, lcd_de 0.
  - lcd_hsync=ihs, lcd_vsync=ivs (inactive levels), startpipe 0.
- startpipe = registered enable; cleared in IDLE.
- Horizontal FSM: IDLE -> HSYNC (hsw+1 cycles) -> HBP (hbp+1) -> HACT (ppl+1) -> HFP (hfp+1) -> HSYNC.
  - Line length = hsw+hbp+ppl+hfp+4 cycles.
  - hcnt counts down from the loaded field; the state advances when hcnt==0.
- Vertical FSM advances on the last cycle of HFP: VSYNC (vsw+1 lines) -> VBP (vbp+1) -> VACT (lpp+1) -> VFP (vfp+1) -> VSYNC.
- Config shadowing: all geometry and polarity inputs are latched into shadow registers on IDLE->run and on each frame wrap (VFP end). Mid-frame input changes have no effect until the next frame.
- Start-up: enable sampled 1 in IDLE -> next cycle is the first HSYNC cycle of VSYNC line 0.
- Outputs are registered from current state and change one edge after the state:
  - lcd_hsync = (h==HSYNC) ^ ihs
  - lcd_vsync = (v==VSYNC) ^ ivs
  - lcd_de = (h==HACT && v==VACT)
- consume = (h==HACT && v==VACT). Combinational stall = pixel_valid & ~consume.
  - Effect: the serializer primes its pipeline during blanking, then holds one valid pixel until the first active slot.
- On consume:
  - pixel_valid=1: lcd_data <= pixel.
  - pixel_valid=0: lcd_data <= 0 and underflow <= 1. underflow stays set until reset or a rising edge of enable.
- Outside consume: lcd_data <= 0.
- enable sampled 0 at any point: next edge goes to IDLE, counters clear, outputs go inactive, startpipe drops. Partial frames are abandoned.
- Reset mid-frame behaves exactly like the reset state above.
- All-zero config is legal: 1-cycle phases, 4-cycle line, 4-line frame.

Decomposition:
- Package lcd_pkg holds:
  - typedef enum h_state_t {H_IDLE,H_SYNC,H_BP,H_ACT,H_FP}
  - typedef enum v_state_t {V_SYNC,V_BP,V_ACT,V_FP}
  - width constants.
- One sub-module, lcd_phase_counter: loadable down-counter with a terminal flag, instantiated once for horizontal and once for vertical.

Test Plan:
- Config hsw=1, hbp=0, ppl=3, hfp=0, vsw=0, vbp=0, lpp=1, vfp=0, ihs=ivs=0; serializer model always valid with incrementing pixels.
  -> Each line is 8 cycles, each frame is 40 cycles.
  -> lcd_hsync high 2 cycles per line; lcd_vsync high 8 cycles per frame.
  -> lcd_de high 4 cycles on lines 2-3; lcd_data = 1, 2, 3, 4 … in order; underflow stays 0.
- Same config with ihs=ivs=1.
  -> Sync waveforms are inverted; idle level is 1.
- pixel_valid forced 0 during the second active pixel.
  -> lcd_data=0 in that slot; underflow rises and stays 1 until enable toggles.
- Change ppl from 3 to 7 mid-frame.
  -> Current frame keeps 4-pixel lines; the next frame has 8-pixel lines (12-cycle line).
- Drop enable during VACT.
  -> Next edge: IDLE; lcd_de=0, syncs inactive, startpipe=0.
  -> Re-enable: HSYNC of VSYNC line 0 on the following cycle.
- Assert reset=0 for one edge mid-HACT.
  -> All outputs take their reset values on that edge; the stall equation holds throughout.

Source files
------------

// File: rtl/lcd_tft_timing_pkg.sv
// Shared types and defaults for the TFT raster timing generator.
// Holds the horizontal/vertical phase encodings and their successor functions.
package lcd_pkg;

    localparam int H_W_DEF   = 11;
    localparam int V_W_DEF   = 11;
    localparam int PIX_W_DEF = 24;

    typedef enum logic [2:0] {
        H_IDLE = 3'd0,
        H_SYNC = 3'd1,
        H_BP   = 3'd2,
        H_ACT  = 3'd3,
        H_FP   = 3'd4
    } h_state_t;

    typedef enum logic [1:0] {
        V_SYNC = 2'd0,
        V_BP   = 2'd1,
        V_ACT  = 2'd2,
        V_FP   = 2'd3
    } v_state_t;

    function automatic h_state_t h_next(input h_state_t h);
        h_state_t n;
        case (h)
            H_SYNC:  n = H_BP;
            H_BP:    n = H_ACT;
            H_ACT:   n = H_FP;
            H_FP:    n = H_SYNC;
            default: n = H_IDLE;
        endcase
        return n;
    endfunction

    function automatic v_state_t v_next(input v_state_t v);
        v_state_t n;
        case (v)
            V_SYNC:  n = V_BP;
            V_BP:    n = V_ACT;
            V_ACT:   n = V_FP;
            V_FP:    n = V_SYNC;
            default: n = V_SYNC;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lcd_tft_timing_if.sv
// Geometry, serializer handshake and panel bus of the TFT timing stage.
// master drives configuration and pixels; slave is the timing generator.
interface lcd_tft_timing_if #(
    parameter int H_W   = 11,
    parameter int V_W   = 11,
    parameter int PIX_W = 24
);
    logic             enable;
    logic [H_W-1:0]   ppl;
    logic [H_W-1:0]   hsw;
    logic [H_W-1:0]   hbp;
    logic [H_W-1:0]   hfp;
    logic [V_W-1:0]   lpp;
    logic [V_W-1:0]   vsw;
    logic [V_W-1:0]   vbp;
    logic [V_W-1:0]   vfp;
    logic             ihs;
    logic             ivs;
    logic [PIX_W-1:0] pixel;
    logic             pixel_valid;
    logic             stall;
    logic             startpipe;
    logic             lcd_hsync;
    logic             lcd_vsync;
    logic             lcd_de;
    logic [PIX_W-1:0] lcd_data;
    logic             underflow;

    modport master (
        output enable, ppl, hsw, hbp, hfp, lpp, vsw, vbp, vfp, ihs, ivs,
        output pixel, pixel_valid,
        input  stall, startpipe, lcd_hsync, lcd_vsync, lcd_de, lcd_data, underflow
    );

    modport slave (
        input  enable, ppl, hsw, hbp, hfp, lpp, vsw, vbp, vfp, ihs, ivs,
        input  pixel, pixel_valid,
        output stall, startpipe, lcd_hsync, lcd_vsync, lcd_de, lcd_data, underflow
    );
endinterface

// File: rtl/lcd_tft_timing_phase_counter.sv
// Loadable down-counter that times one raster phase; zero_o marks its last step.
module lcd_phase_counter #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins over load, load wins over decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_tft_timing.sv
// TFT raster timing generator: HSYNC/VSYNC/DE from shadowed frame geometry,
// pulling one pixel per active cycle from the palette serializer.
module lcd_tft_timing
    import lcd_pkg::*;
#(
    parameter int H_W   = H_W_DEF,
    parameter int V_W   = V_W_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input logic            clk,
    input logic            reset,
    lcd_tft_timing_if.slave bus
);

    logic [H_W-1:0]   hsw_q, hbp_q, ppl_q, hfp_q;
    logic [V_W-1:0]   vsw_q, vbp_q, lpp_q, vfp_q;
    logic             ihs_q, ivs_q;

    h_state_t         h_q, h_d;
    v_state_t         v_q, v_d;

    logic             startpipe_q;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic             underflow_q, underflow_d;
    logic [PIX_W-1:0] data_q, data_d;

    logic             h_zero_s, v_zero_s;
    logic             consume_s, line_end_s, frame_end_s, cfg_load_s, cnt_clr_s;
    logic             h_load_s, h_dec_s, v_load_s, v_dec_s;
    logic [H_W-1:0]   h_val_s;
    logic [V_W-1:0]   v_val_s;

    assign consume_s   = (h_q == H_ACT) && (v_q == V_ACT);
    assign line_end_s  = (h_q == H_FP) && h_zero_s;
    assign frame_end_s = line_end_s && (v_q == V_FP) && v_zero_s;
    // Shadows refresh on start-up and on frame wrap, so the new frame's first
    // HSYNC/VSYNC counts must be taken straight from the live inputs.
    assign cfg_load_s  = bus.enable && ((h_q == H_IDLE) || frame_end_s);

    assign bus.stall     = bus.pixel_valid & ~consume_s;
    assign bus.startpipe = startpipe_q;
    assign bus.lcd_hsync = hsync_q;
    assign bus.lcd_vsync = vsync_q;
    assign bus.lcd_de    = de_q;
    assign bus.lcd_data  = data_q;
    assign bus.underflow = underflow_q;

    lcd_phase_counter #(.W(H_W)) u_hcnt (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (cnt_clr_s),
        .load_i     (h_load_s),
        .load_val_i (h_val_s),
        .dec_i      (h_dec_s),
        .zero_o     (h_zero_s)
    );

    lcd_phase_counter #(.W(V_W)) u_vcnt (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (cnt_clr_s),
        .load_i     (v_load_s),
        .load_val_i (v_val_s),
        .dec_i      (v_dec_s),
        .zero_o     (v_zero_s)
    );

    // Phase sequencing and counter load/decrement control.
    always_comb begin
        h_d       = h_q;
        v_d       = v_q;
        h_load_s  = 1'b0;
        h_dec_s   = 1'b0;
        h_val_s   = '0;
        v_load_s  = 1'b0;
        v_dec_s   = 1'b0;
        v_val_s   = '0;
        cnt_clr_s = 1'b0;
        if (!bus.enable) begin
            h_d       = H_IDLE;
            v_d       = V_SYNC;
            cnt_clr_s = 1'b1;
        end else if (h_q == H_IDLE) begin
            h_d      = H_SYNC;
            v_d      = V_SYNC;
            h_load_s = 1'b1;
            h_val_s  = bus.hsw;
            v_load_s = 1'b1;
            v_val_s  = bus.vsw;
        end else if (h_zero_s) begin
            h_d      = h_next(h_q);
            h_load_s = 1'b1;
            case (h_q)
                H_SYNC:  h_val_s = hbp_q;
                H_BP:    h_val_s = ppl_q;
                H_ACT:   h_val_s = hfp_q;
                H_FP:    h_val_s = frame_end_s ? bus.hsw : hsw_q;
                default: h_val_s = '0;
            endcase
            if (line_end_s) begin
                if (v_zero_s) begin
                    v_d      = v_next(v_q);
                    v_load_s = 1'b1;
                    case (v_q)
                        V_SYNC:  v_val_s = vbp_q;
                        V_BP:    v_val_s = lpp_q;
                        V_ACT:   v_val_s = vfp_q;
                        V_FP:    v_val_s = bus.vsw;
                        default: v_val_s = '0;
                    endcase
                end else begin
                    v_dec_s = 1'b1;
                end
            end else begin
                v_dec_s = 1'b0;
            end
        end else begin
            h_dec_s = 1'b1;
        end
    end

    // Panel outputs follow the current phase one edge later; idle shows the
    // inactive sync levels of the live polarity inputs.
    always_comb begin
        hsync_d = bus.ihs;
        vsync_d = bus.ivs;
        de_d    = 1'b0;
        data_d  = '0;
        if (bus.enable && (h_q != H_IDLE)) begin
            hsync_d = (h_q == H_SYNC) ^ ihs_q;
            vsync_d = (v_q == V_SYNC) ^ ivs_q;
            de_d    = consume_s;
            data_d  = (consume_s && bus.pixel_valid) ? bus.pixel : '0;
        end else begin
            hsync_d = bus.ihs;
            vsync_d = bus.ivs;
        end
    end

    // Sticky underflow, cleared only by reset or a fresh enable.
    always_comb begin
        underflow_d = underflow_q;
        if (bus.enable && !startpipe_q) begin
            underflow_d = 1'b0;
        end else if (bus.enable && consume_s && !bus.pixel_valid) begin
            underflow_d = 1'b1;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // State, shadow configuration and registered panel outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            h_q         <= H_IDLE;
            v_q         <= V_SYNC;
            startpipe_q <= 1'b0;
            hsync_q     <= bus.ihs;
            vsync_q     <= bus.ivs;
            de_q        <= 1'b0;
            data_q      <= '0;
            underflow_q <= 1'b0;
            hsw_q       <= '0;
            hbp_q       <= '0;
            ppl_q       <= '0;
            hfp_q       <= '0;
            vsw_q       <= '0;
            vbp_q       <= '0;
            lpp_q       <= '0;
            vfp_q       <= '0;
            ihs_q       <= 1'b0;
            ivs_q       <= 1'b0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            startpipe_q <= bus.enable;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            data_q      <= data_d;
            underflow_q <= underflow_d;
            if (cfg_load_s) begin
                hsw_q <= bus.hsw;
                hbp_q <= bus.hbp;
                ppl_q <= bus.ppl;
                hfp_q <= bus.hfp;
                vsw_q <= bus.vsw;
                vbp_q <= bus.vbp;
                lpp_q <= bus.lpp;
                vfp_q <= bus.vfp;
                ihs_q <= bus.ihs;
                ivs_q <= bus.ivs;
            end
        end
    end

endmodule
